ai_score_packer: RTL and testbench
==================================

AI_SCORE_PACKER -- requirements
Module: AI_score_packer

Interface
REQ-001 Parameter GUARD, default 10, minimum cycles between score_rdy pulses; covers the downstream decision scan of 1 load + 8 compare + 1 decide.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 init  input  1  synchronous clear of all frame state.
REQ-005 in_valid  input  1  one class sample present this cycle.
REQ-006 in_class  input  3  class index 0..7 of the sample.
REQ-007 in_score  input  8  score increment for the class.
REQ-008 in_dist  input  24  match distance of the sample.
REQ-009 frame_end  input  1  single-cycle pulse closing the current frame.
REQ-010 reg1  output  32  packed scores: class0 [31:24], class1 [23:16], class2 [15:8], class3 [7:0].
REQ-011 reg2  output  32  packed scores: class4 [31:24], class5 [23:16], class6 [15:8], class7 [7:0].
REQ-012 min  output  24  smallest in_dist of the emitted frame; 24'hFFFFFF when the frame had no samples.
REQ-013 score_rdy  output  1  one-cycle pulse, outputs newly valid.
REQ-014 busy  output  1  high while guard counter is nonzero or a frame is pending.
REQ-015 overrun  output  1  sticky, a frame_end arrived while one was already pending.

Function
REQ-016 Internal state SHALL be: 8 accumulators acc[0..7] (8b), acc_min (24b), guard counter, pending flag.
REQ-017 On in_valid, acc[in_class] SHALL become acc + in_score, saturating at 8'hFF.
REQ-018 On in_valid, acc_min SHALL become min(acc_min, in_dist), unsigned compare; ties keep the value.
REQ-019 An emission SHALL occur in a cycle with guard==0 and either frame_end or pending high.
REQ-020 Emission snapshot SHALL include any in_valid sample of the same cycle.
REQ-021 Latency: emission at cycle N gives reg1/reg2/min updated and score_rdy=1 during cycle N+1.
REQ-022 On emission, accumulators SHALL clear to 0, acc_min SHALL clear to 24'hFFFFFF, pending SHALL clear, and guard SHALL load GUARD.
REQ-023 guard SHALL decrement by 1 per cycle while nonzero and SHALL not wrap below 0.
REQ-024 frame_end with guard!=0 SHALL set pending; samples SHALL keep accumulating into the pending frame until it is emitted.
REQ-025 frame_end while pending is already set SHALL merge into the pending frame and set overrun.
REQ-026 reg1, reg2 and min SHALL hold their values between emissions; score_rdy is high for exactly 1 cycle per emission.
REQ-027 States SHALL be: IDLE (guard 0, no pending), GUARD (guard>0, no pending) and PEND (pending). Transitions: IDLE->GUARD on emission; GUARD->IDLE at guard 1->0; GUARD->PEND on frame_end; PEND->GUARD on emission.
REQ-028 init SHALL have priority over in_valid and frame_end in the same cycle; the sample and the frame_end SHALL be dropped.
REQ-029 init SHALL clear accumulators, acc_min, guard, pending and overrun, and SHALL set reg1=0, reg2=0, min=FFFFFF and score_rdy=0 at the next edge.

Reset
REQ-030 rst SHALL asynchronously force reg1=0, reg2=0, min=24'hFFFFFF, score_rdy=0, busy=0 and overrun=0.
REQ-031 rst SHALL force accumulators to 0, acc_min to FFFFFF, guard to 0, pending to 0 and state to IDLE.
REQ-032 rst asserted mid-frame or during GUARD or PEND SHALL discard all frame data; no score_rdy SHALL be issued after release.
REQ-033 First cycle after rst release SHALL accept in_valid normally.

Verification
REQ-034 Samples (c2,s30,d500), (c2,s40,d200), (c7,s5,d900), then frame_end -> next cycle score_rdy=1, reg1=0x0000_4600, reg2=0x0000_0005, min=200.
REQ-035 Class 3 samples of 200 and 100, then frame_end -> reg1[7:0]=0xFF (saturation).
REQ-036 frame_end with no samples -> reg1=0, reg2=0, min=FFFFFF, score_rdy pulses.
REQ-037 frame_end 3 cycles after a prior emission -> busy=1, no pulse until guard expires, then pulse with scores accumulated up to then; score_rdy pulses are spaced >=10 cycles apart.
REQ-038 Two frame_end pulses inside the guard window -> overrun=1, a single deferred emission; init clears overrun.
REQ-039 init coincident with in_valid and frame_end -> no score_rdy, outputs 0/0/FFFFFF; rst mid-PEND -> no later pulse.

Source files
------------

// File: rtl/ai_score_packer.sv
// Per-frame class score packer: accumulates saturating scores and minimum match
// distance per frame, then emits packed results no more often than every GUARD cycles.
module ai_score_packer #(
  parameter int GUARD = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        in_valid,
  input  logic [2:0]  in_class,
  input  logic [7:0]  in_score,
  input  logic [23:0] in_dist,
  input  logic        frame_end,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [23:0] min,
  output logic        score_rdy,
  output logic        busy,
  output logic        overrun
);

  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_PEND  = 2'd2
  } state_t;

  state_t         state;
  logic [7:0]     acc [8];
  logic [7:0]     acc_nxt [8];
  logic [23:0]    acc_min;
  logic [23:0]    min_nxt;
  logic [GW-1:0]  guard_cnt;
  logic [8:0]     sum;
  logic           pending;
  logic           emit;

  assign pending = (state == S_PEND);
  assign emit    = (guard_cnt == '0) && (frame_end || pending);
  assign busy    = (guard_cnt != '0) || pending;

  // Frame contents including this cycle's sample, so an emission can snapshot it.
  always_comb begin
    acc_nxt = acc;
    min_nxt = acc_min;
    sum     = 9'd0;
    if (in_valid) begin
      sum = {1'b0, acc[in_class]} + {1'b0, in_score};
      acc_nxt[in_class] = sum[8] ? 8'hFF : sum[7:0];
      if (in_dist < acc_min) begin
        min_nxt = in_dist;
      end else begin
        min_nxt = acc_min;
      end
    end else begin
      sum = 9'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '{default: 8'h00};
      acc_min   <= 24'hFFFFFF;
      guard_cnt <= '0;
      overrun   <= 1'b0;
      reg1      <= 32'h0000_0000;
      reg2      <= 32'h0000_0000;
      min       <= 24'hFFFFFF;
      score_rdy <= 1'b0;
    end else if (init) begin
      state     <= S_IDLE;
      acc       <= '{default: 8'h00};
      acc_min   <= 24'hFFFFFF;
      guard_cnt <= '0;
      overrun   <= 1'b0;
      reg1      <= 32'h0000_0000;
      reg2      <= 32'h0000_0000;
      min       <= 24'hFFFFFF;
      score_rdy <= 1'b0;
    end else begin
      score_rdy <= 1'b0;
      if (frame_end && pending) begin
        overrun <= 1'b1;
      end
      if (emit) begin
        reg1      <= {acc_nxt[0], acc_nxt[1], acc_nxt[2], acc_nxt[3]};
        reg2      <= {acc_nxt[4], acc_nxt[5], acc_nxt[6], acc_nxt[7]};
        min       <= min_nxt;
        score_rdy <= 1'b1;
        acc       <= '{default: 8'h00};
        acc_min   <= 24'hFFFFFF;
        guard_cnt <= GW'(GUARD);
        state     <= S_GUARD;
      end else begin
        acc     <= acc_nxt;
        acc_min <= min_nxt;
        if (guard_cnt != '0) begin
          guard_cnt <= guard_cnt - GW'(1);
        end
        // A frame_end in IDLE always emits, so only GUARD has transitions here.
        case (state)
          S_IDLE:  state <= S_IDLE;
          S_GUARD: begin
            if (frame_end) begin
              state <= S_PEND;
            end else if (guard_cnt == GW'(1)) begin
              state <= S_IDLE;
            end
          end
          S_PEND:  state <= S_PEND;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ai_score_packer.sv
// Directed testbench for ai_score_packer with hand-computed expectations.
module tb_ai_score_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic        in_valid;
  logic [2:0]  in_class;
  logic [7:0]  in_score;
  logic [23:0] in_dist;
  logic        frame_end;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [23:0] min;
  logic        score_rdy;
  logic        busy;
  logic        overrun;

  int vectors = 0;
  int errors  = 0;
  int first_k;
  int pulses;

  ai_score_packer #(.GUARD(10)) dut (
    .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_class(in_class),
    .in_score(in_score), .in_dist(in_dist), .frame_end(frame_end),
    .reg1(reg1), .reg2(reg2), .min(min), .score_rdy(score_rdy),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge; outputs are sampled 1ns after the next posedge.
  task automatic step(input logic v, input logic [2:0] c, input logic [7:0] s,
                      input logic [23:0] d, input logic fe, input logic ini);
    @(negedge clk);
    in_valid = v; in_class = c; in_score = s; in_dist = d; frame_end = fe; init = ini;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 8'd0, 24'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; in_valid = 1'b0; in_class = 3'd0; in_score = 8'd0;
    in_dist = 24'd0; frame_end = 1'b0;
    #3;
    chk("rst_reg1", reg1, 32'h0);
    chk("rst_reg2", reg2, 32'h0);
    chk("rst_min", {8'h00, min}, 32'h00FF_FFFF);
    chk("rst_rdy", {31'd0, score_rdy}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Basic accumulation and packing
    step(1'b1, 3'd2, 8'd30, 24'd500, 1'b0, 1'b0);
    step(1'b1, 3'd2, 8'd40, 24'd200, 1'b0, 1'b0);
    step(1'b1, 3'd7, 8'd5,  24'd900, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'd0,  24'd0,   1'b1, 1'b0);
    chk("basic_rdy", {31'd0, score_rdy}, 32'd1);
    chk("basic_reg1", reg1, 32'h0000_4600);
    chk("basic_reg2", reg2, 32'h0000_0005);
    chk("basic_min", {8'h00, min}, 32'd200);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    idle();
    chk("hold_rdy", {31'd0, score_rdy}, 32'd0);
    chk("hold_reg1", reg1, 32'h0000_4600);

    // Deferred emission: frame_end at cycle 3 after the emission, pulse at cycle 11
    idle();
    step(1'b1, 3'd3, 8'd7, 24'd1000, 1'b1, 1'b0);
    chk("defer_busy", {31'd0, busy}, 32'd1);
    chk("defer_rdy", {31'd0, score_rdy}, 32'd0);
    step(1'b1, 3'd0, 8'd9, 24'd50, 1'b0, 1'b0);
    first_k = -1;
    for (int k = 5; k <= 20; k++) begin
      idle();
      if (score_rdy && first_k < 0) first_k = k;
    end
    chk("defer_cycle", first_k, 32'd11);
    chk("defer_reg1", reg1, 32'h0900_0007);
    chk("defer_reg2", reg2, 32'h0);
    chk("defer_min", {8'h00, min}, 32'd50);
    chk("defer_ovr", {31'd0, overrun}, 32'd0);

    // Let guard expire, then emit a fresh frame as cycle 0 for the overrun test
    for (int k = 0; k < 12; k++) idle();
    step(1'b0, 3'd0, 8'd0, 24'd0, 1'b1, 1'b0);
    chk("ovr_emit0", {31'd0, score_rdy}, 32'd1);
    step(1'b0, 3'd0, 8'd0, 24'd0, 1'b1, 1'b0);
    step(1'b0, 3'd0, 8'd0, 24'd0, 1'b1, 1'b0);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    pulses = 0; first_k = -1;
    for (int k = 3; k <= 30; k++) begin
      idle();
      if (score_rdy) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    chk("ovr_pulses", pulses, 32'd1);
    chk("ovr_cycle", first_k, 32'd11);
    chk("ovr_min", {8'h00, min}, 32'h00FF_FFFF);
    chk("ovr_idle_busy", {31'd0, busy}, 32'd0);
    step(1'b0, 3'd0, 8'd0, 24'd0, 1'b0, 1'b1);
    chk("init_ovr", {31'd0, overrun}, 32'd0);

    // Saturation
    step(1'b1, 3'd3, 8'd200, 24'h10, 1'b0, 1'b0);
    step(1'b1, 3'd3, 8'd100, 24'h20, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'd0,   24'd0,  1'b1, 1'b0);
    chk("sat_rdy", {31'd0, score_rdy}, 32'd1);
    chk("sat_reg1", reg1, 32'h0000_00FF);
    chk("sat_min", {8'h00, min}, 32'h10);
    for (int k = 0; k < 12; k++) idle();

    // Empty frame
    step(1'b0, 3'd0, 8'd0, 24'd0, 1'b1, 1'b0);
    chk("empty_rdy", {31'd0, score_rdy}, 32'd1);
    chk("empty_reg1", reg1, 32'h0);
    chk("empty_reg2", reg2, 32'h0);
    chk("empty_min", {8'h00, min}, 32'h00FF_FFFF);
    for (int k = 0; k < 12; k++) idle();

    // init beats a coincident sample and frame_end, and clears the open frame
    step(1'b1, 3'd1, 8'd50, 24'd7, 1'b0, 1'b0);
    step(1'b1, 3'd4, 8'd9,  24'd3, 1'b1, 1'b1);
    chk("init_rdy", {31'd0, score_rdy}, 32'd0);
    chk("init_reg1", reg1, 32'h0);
    chk("init_min", {8'h00, min}, 32'h00FF_FFFF);
    chk("init_busy", {31'd0, busy}, 32'd0);
    step(1'b0, 3'd0, 8'd0, 24'd0, 1'b1, 1'b0);
    chk("post_init_rdy", {31'd0, score_rdy}, 32'd1);
    chk("post_init_reg1", reg1, 32'h0);
    chk("post_init_reg2", reg2, 32'h0);
    chk("post_init_min", {8'h00, min}, 32'h00FF_FFFF);

    // Reset while a frame is pending discards it
    step(1'b1, 3'd5, 8'd1, 24'd1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 8'd0, 24'd0, 1'b1, 1'b0);
    chk("pend_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; frame_end = 1'b0; rst = 1'b1;
    #2;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_min", {8'h00, min}, 32'h00FF_FFFF);
    @(negedge clk); rst = 1'b0;
    step(1'b1, 3'd6, 8'd33, 24'd77, 1'b0, 1'b0);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      idle();
      if (score_rdy) pulses++;
    end
    chk("midrst_nopulse", pulses, 32'd0);
    step(1'b0, 3'd0, 8'd0, 24'd0, 1'b1, 1'b0);
    chk("after_rst_rdy", {31'd0, score_rdy}, 32'd1);
    chk("after_rst_reg2", reg2, 32'h0000_2100);
    chk("after_rst_min", {8'h00, min}, 32'd77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
